// File: rtl/t_bird_pkg.sv
// Shared types and constants for the Thunderbird lamp monitor.
package t_bird_pkg;

   typedef enum logic [3:0] {
      M_IDLE = 4'd0,
      M_L1   = 4'd1,
      M_L2   = 4'd2,
      M_L3   = 4'd3,
      M_R1   = 4'd4,
      M_R2   = 4'd5,
      M_R3   = 4'd6,
      M_HAZ  = 4'd7,
      M_SYNC = 4'd8
   } mon_state_s;

   typedef enum logic [2:0] {
      CLS_IDLE,
      CLS_L1,
      CLS_L2,
      CLS_L3,
      CLS_RA,
      CLS_R3,
      CLS_HAZ,
      CLS_ILLEGAL
   } lamp_class_s;

   // Lamp vector order is {la,lb,lc,ra,rb,rc}
   localparam logic [5:0] P_IDLE = 6'b000000;
   localparam logic [5:0] P_L1   = 6'b100000;
   localparam logic [5:0] P_L2   = 6'b110000;
   localparam logic [5:0] P_L3   = 6'b111000;
   localparam logic [5:0] P_RA   = 6'b000110;
   localparam logic [5:0] P_R3   = 6'b000101;
   localparam logic [5:0] P_HAZ  = 6'b001001;

   localparam logic [1:0] MODE_IDLE  = 2'd0;
   localparam logic [1:0] MODE_LEFT  = 2'd1;
   localparam logic [1:0] MODE_RIGHT = 2'd2;
   localparam logic [1:0] MODE_HAZ   = 2'd3;

   function automatic logic [1:0] mode_of(input mon_state_s s);
      case (s)
         M_L1, M_L2, M_L3: mode_of = MODE_LEFT;
         M_R1, M_R2, M_R3: mode_of = MODE_RIGHT;
         M_HAZ:            mode_of = MODE_HAZ;
         default:          mode_of = MODE_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/t_bird_lamp_decode.sv
// Classifies a six-lamp vector against the legal pattern set.
module t_bird_lamp_decode
   import t_bird_pkg::*;
(
   input  logic [5:0]  lamps,
   output lamp_class_s cls
);

   always_comb begin
      case (lamps)
         P_IDLE:  cls = CLS_IDLE;
         P_L1:    cls = CLS_L1;
         P_L2:    cls = CLS_L2;
         P_L3:    cls = CLS_L3;
         P_RA:    cls = CLS_RA;
         P_R3:    cls = CLS_R3;
         P_HAZ:   cls = CLS_HAZ;
         default: cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/t_bird_lamp_monitor.sv
// Passive sequence checker on the Thunderbird lamp outputs.
// Define T_BIRD_LAMP_SYNC_EN to add a 2-flop input synchronizer (4-clock latency).
module t_bird_lamp_monitor
   import t_bird_pkg::*;
#(
   parameter int CNT_W = 8
)(
   input  logic             clk,
   input  logic             clr,
   input  logic             la,
   input  logic             lb,
   input  logic             lc,
   input  logic             ra,
   input  logic             rb,
   input  logic             rc,
   output logic [1:0]       mode,
   output logic             seq_done,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] seq_count,
   output logic [CNT_W-1:0] err_count,
   output logic [3:0]       mstate
);

   logic [5:0]  lamps;
   logic [5:0]  samp;
   lamp_class_s cls;
   mon_state_s  state, nxt;
   logic        nxt_err, nxt_done;

   assign lamps = {la, lb, lc, ra, rb, rc};

`ifdef T_BIRD_LAMP_SYNC_EN
   logic [5:0] sync1, sync2;
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1 <= '0;
         sync2 <= '0;
         samp  <= '0;
      end else begin
         sync1 <= lamps;
         sync2 <= sync1;
         samp  <= sync2;
      end
   end
`else
   always_ff @(posedge clk or posedge clr) begin
      if (clr) samp <= '0;
      else     samp <= lamps;
   end
`endif

   t_bird_lamp_decode u_dec (
      .lamps (samp),
      .cls   (cls)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state <= M_IDLE;
      else     state <= nxt;
   end

   // Any class not listed for a state falls through to M_SYNC.
   always_comb begin
      nxt = M_SYNC;
      case (state)
         M_IDLE: case (cls)
            CLS_IDLE: nxt = M_IDLE;
            CLS_L1:   nxt = M_L1;
            CLS_RA:   nxt = M_R1;
            CLS_HAZ:  nxt = M_HAZ;
            default:  nxt = M_SYNC;
         endcase
         M_L1: if (cls == CLS_L2) nxt = M_L2;
               else if (cls == CLS_HAZ) nxt = M_HAZ;
         M_L2: if (cls == CLS_L3) nxt = M_L3;
               else if (cls == CLS_HAZ) nxt = M_HAZ;
         M_R1: if (cls == CLS_RA) nxt = M_R2;
               else if (cls == CLS_HAZ) nxt = M_HAZ;
         M_R2: if (cls == CLS_R3) nxt = M_R3;
               else if (cls == CLS_HAZ) nxt = M_HAZ;
         M_L3, M_R3, M_HAZ, M_SYNC: if (cls == CLS_IDLE) nxt = M_IDLE;
         default: nxt = M_SYNC;
      endcase
      // Only the entry into M_SYNC is flagged: one err per violation burst.
      nxt_err  = (nxt == M_SYNC) && (state != M_SYNC);
      nxt_done = (nxt == M_IDLE) && (state inside {M_L3, M_R3, M_HAZ});
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         seq_done   <= 1'b0;
         err        <= 1'b0;
         err_sticky <= 1'b0;
         seq_count  <= '0;
         err_count  <= '0;
      end else begin
         seq_done <= nxt_done;
         err      <= nxt_err;
         if (nxt_err) err_sticky <= 1'b1;
         if (nxt_done && seq_count != '1) seq_count <= seq_count + 1'b1;
         if (nxt_err && err_count != '1)  err_count <= err_count + 1'b1;
      end
   end

   assign mode   = mode_of(state);
   assign mstate = state;

endmodule

// File: tb/tb_t_bird_lamp_monitor.sv
// Directed table-driven bench for t_bird_lamp_monitor, with a CNT_W=2 twin for saturation.
module tb_t_bird_lamp_monitor;
   import t_bird_pkg::*;

`ifdef T_BIRD_LAMP_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif
   localparam int N = 34;

   logic clk = 1'b0;
   logic clr;
   logic la, lb, lc, ra, rb, rc;

   logic [1:0] mode;
   logic       seq_done, err, err_sticky;
   logic [7:0] seq_count, err_count;
   logic [3:0] mstate;

   logic [1:0] s_mode;
   logic       s_done, s_err, s_sticky;
   logic [1:0] s_seqc, s_errc;
   logic [3:0] s_state;

   t_bird_lamp_monitor #(.CNT_W(8)) u_dut (
      .clk(clk), .clr(clr), .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
      .mode(mode), .seq_done(seq_done), .err(err), .err_sticky(err_sticky),
      .seq_count(seq_count), .err_count(err_count), .mstate(mstate)
   );

   t_bird_lamp_monitor #(.CNT_W(2)) u_sat (
      .clk(clk), .clr(clr), .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
      .mode(s_mode), .seq_done(s_done), .err(s_err), .err_sticky(s_sticky),
      .seq_count(s_seqc), .err_count(s_errc), .mstate(s_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] lamps;
      logic [3:0] st;
      logic [1:0] md;
      logic       done;
      logic       er;
      logic       sticky;
      int         sc;
      int         ec;
   } vec_t;

   vec_t tbl [N];
   int   total  = 0;
   int   passed = 0;

   function automatic vec_t v(input logic [5:0] l, input logic [3:0] st, input logic [1:0] md,
                              input logic d, input logic e, input logic s, input int sc, input int ec);
      vec_t r;
      r.lamps = l; r.st = st; r.md = md; r.done = d; r.er = e; r.sticky = s; r.sc = sc; r.ec = ec;
      return r;
   endfunction

   function automatic int sat3(input int x);
      return (x > 3) ? 3 : x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   task automatic set_lamps(input logic [5:0] l);
      {la, lb, lc, ra, rb, rc} = l;
   endtask

   initial begin
      logic [5:0] bad;
      int         k;
      bad = 6'b010000;
      // left, right, hazard abort
      tbl[0]  = v(P_IDLE, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = v(P_L1,   1, 1, 0, 0, 0, 0, 0);
      tbl[2]  = v(P_L2,   2, 1, 0, 0, 0, 0, 0);
      tbl[3]  = v(P_L3,   3, 1, 0, 0, 0, 0, 0);
      tbl[4]  = v(P_IDLE, 0, 0, 1, 0, 0, 1, 0);
      tbl[5]  = v(P_RA,   4, 2, 0, 0, 0, 1, 0);
      tbl[6]  = v(P_RA,   5, 2, 0, 0, 0, 1, 0);
      tbl[7]  = v(P_R3,   6, 2, 0, 0, 0, 1, 0);
      tbl[8]  = v(P_IDLE, 0, 0, 1, 0, 0, 2, 0);
      tbl[9]  = v(P_L1,   1, 1, 0, 0, 0, 2, 0);
      tbl[10] = v(P_HAZ,  7, 3, 0, 0, 0, 2, 0);
      tbl[11] = v(P_IDLE, 0, 0, 1, 0, 0, 3, 0);
      // illegal pattern burst
      tbl[12] = v(bad,    8, 0, 0, 1, 1, 3, 1);
      tbl[13] = v(bad,    8, 0, 0, 0, 1, 3, 1);
      tbl[14] = v(P_IDLE, 0, 0, 0, 0, 1, 3, 1);
      // illegal transition then recovery
      tbl[15] = v(P_L1,   1, 1, 0, 0, 1, 3, 1);
      tbl[16] = v(P_L3,   8, 0, 0, 1, 1, 3, 2);
      tbl[17] = v(P_IDLE, 0, 0, 0, 0, 1, 3, 2);
      tbl[18] = v(P_L1,   1, 1, 0, 0, 1, 3, 2);
      tbl[19] = v(P_L2,   2, 1, 0, 0, 1, 3, 2);
      tbl[20] = v(P_L3,   3, 1, 0, 0, 1, 3, 2);
      tbl[21] = v(P_IDLE, 0, 0, 1, 0, 1, 4, 2);
      // direct hazard, hazard aborting a right turn
      tbl[22] = v(P_HAZ,  7, 3, 0, 0, 1, 4, 2);
      tbl[23] = v(P_IDLE, 0, 0, 1, 0, 1, 5, 2);
      tbl[24] = v(P_RA,   4, 2, 0, 0, 1, 5, 2);
      tbl[25] = v(P_HAZ,  7, 3, 0, 0, 1, 5, 2);
      tbl[26] = v(P_IDLE, 0, 0, 1, 0, 1, 6, 2);
      // repeated L3 is illegal; R3 straight from idle is illegal
      tbl[27] = v(P_L1,   1, 1, 0, 0, 1, 6, 2);
      tbl[28] = v(P_L2,   2, 1, 0, 0, 1, 6, 2);
      tbl[29] = v(P_L3,   3, 1, 0, 0, 1, 6, 2);
      tbl[30] = v(P_L3,   8, 0, 0, 1, 1, 6, 3);
      tbl[31] = v(P_IDLE, 0, 0, 0, 0, 1, 6, 3);
      tbl[32] = v(P_R3,   8, 0, 0, 1, 1, 6, 4);
      tbl[33] = v(P_IDLE, 0, 0, 0, 0, 1, 6, 4);

      clr = 1'b1;
      set_lamps(P_IDLE);
      repeat (2) @(posedge clk);
      #1;
      chk("rst mstate", mstate, 0);
      chk("rst mode", mode, 0);
      chk("rst seq_done", seq_done, 0);
      chk("rst err", err, 0);
      chk("rst sticky", err_sticky, 0);
      chk("rst seq_count", seq_count, 0);
      chk("rst err_count", err_count, 0);
      @(negedge clk);
      clr = 1'b0;

      for (int i = 0; i < N + LAT; i++) begin
         @(negedge clk);
         if (i >= LAT) begin
            int r;
            r = i - LAT;
            chk($sformatf("row%0d mstate", r), mstate, tbl[r].st);
            chk($sformatf("row%0d mode", r), mode, tbl[r].md);
            chk($sformatf("row%0d seq_done", r), seq_done, tbl[r].done);
            chk($sformatf("row%0d err", r), err, tbl[r].er);
            chk($sformatf("row%0d sticky", r), err_sticky, tbl[r].sticky);
            chk($sformatf("row%0d seq_count", r), seq_count, tbl[r].sc);
            chk($sformatf("row%0d err_count", r), err_count, tbl[r].ec);
            chk($sformatf("row%0d sat seq_count", r), s_seqc, sat3(tbl[r].sc));
            chk($sformatf("row%0d sat err_count", r), s_errc, sat3(tbl[r].ec));
         end
         if (i < N) set_lamps(tbl[i].lamps);
      end

      // async clear while sitting in M_R2, between clock edges
      set_lamps(P_RA);
      k = 0;
      @(negedge clk);
      while (mstate != 4'd5 && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("reach M_R2", mstate, 4'd5);
      #1 clr = 1'b1;
      #1;
      chk("aclr mstate", mstate, 0);
      chk("aclr mode", mode, 0);
      chk("aclr seq_count", seq_count, 0);
      chk("aclr err_count", err_count, 0);
      chk("aclr sticky", err_sticky, 0);
      chk("aclr sat seq_count", s_seqc, 0);
      set_lamps(P_IDLE);
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;

      // fresh left sequence after clear
      set_lamps(P_L1);
      @(negedge clk) set_lamps(P_L2);
      @(negedge clk) set_lamps(P_L3);
      @(negedge clk) set_lamps(P_IDLE);
      repeat (LAT) @(negedge clk);
      chk("post clr seq_done", seq_done, 1);
      chk("post clr seq_count", seq_count, 1);
      chk("post clr err_count", err_count, 0);
      chk("post clr mstate", mstate, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
